// File: rtl/qacc_pkg.sv
// qacc_pkg: shared types and helpers for the queue accumulator.
// Build option QACC_SAT_EN adds a sticky overflow bit to the result word.
package qacc_pkg;

    localparam int W_DATA_DEF = 16;
    localparam int W_SUM_DEF  = 24;
    localparam int W_CNT_DEF  = 16;
    localparam int W_EXT      = 64;

    // Output register occupancy; FULL means a result is waiting on dout.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } qacc_state_e;

    // Queue word and result word at the default widths.
    typedef struct packed {
        logic                  eot;
        logic [W_DATA_DEF-1:0] data;
    } din_t;

    typedef struct packed {
`ifdef QACC_SAT_EN
        logic                 ovf;
`endif
        logic [W_CNT_DEF-1:0] cnt;
        logic [W_SUM_DEF-1:0] sum;
    } dout_t;

    // Extend the low w bits of d to W_EXT bits, by sign or by zeros.
    function automatic logic [W_EXT-1:0] ext(input logic [W_EXT-1:0] d,
                                             input int w,
                                             input bit sgn);
        logic [W_EXT-1:0] mask;
        logic             msb;
        mask = (64'd1 << w) - 64'd1;
        msb  = |(d & (64'd1 << (w - 1)));
        return (sgn && msb) ? (d | ~mask) : (d & mask);
    endfunction

endpackage

// File: rtl/dti.sv
// dti: valid/ready queue handshake; a word moves when valid and ready are both high.
interface dti #(
    parameter int W = 8
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport producer (output valid, output data, input ready);
    modport consumer (input valid, input data, output ready);
endinterface

// File: rtl/qacc_add.sv
// qacc_add: extends one queue word and adds it to the running sum.
// With QACC_SAT_EN the sum clamps instead of wrapping and a sticky ovf bit is kept.
module qacc_add #(
    parameter int W_DATA = 16,
    parameter int W_SUM  = 24,
    parameter int SIGNED = 0
) (
    input  logic [W_SUM-1:0]  acc_sum,
    input  logic [W_DATA-1:0] data,
`ifdef QACC_SAT_EN
    input  logic              acc_ovf,
    output logic              ovf_next,
`endif
    output logic [W_SUM-1:0]  sum_next
);
    import qacc_pkg::*;

    logic [W_SUM-1:0] addend;

    // Extend to 64 bits then keep the W_SUM LSBs, which also truncates wide data.
    assign addend = W_SUM'(ext(W_EXT'(data), W_DATA, SIGNED != 0));

`ifdef QACC_SAT_EN
    logic [W_SUM:0] raw;

    // Add with carry out, then clamp on unsigned carry or signed overflow.
    always_comb begin
        raw      = {1'b0, acc_sum} + {1'b0, addend};
        sum_next = raw[W_SUM-1:0];
        ovf_next = acc_ovf;
        if (SIGNED != 0) begin
            if ((acc_sum[W_SUM-1] == addend[W_SUM-1]) &&
                (raw[W_SUM-1] != acc_sum[W_SUM-1])) begin
                sum_next = acc_sum[W_SUM-1] ? {1'b1, {(W_SUM-1){1'b0}}}
                                            : {1'b0, {(W_SUM-1){1'b1}}};
                ovf_next = 1'b1;
            end
        end else if (raw[W_SUM]) begin
            sum_next = '1;
            ovf_next = 1'b1;
        end
    end
`else
    // Plain modulo-2^W_SUM add.
    always_comb begin
        sum_next = acc_sum + addend;
    end
`endif

endmodule

// File: rtl/qacc.sv
// qacc: reduces each eot-terminated queue transaction to one {cnt, sum} word.
// Build option QACC_SAT_EN: saturating sum plus sticky ovf bit as MSB of dout.data.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_EMPTY | no result pending; din always accepted
// ST_FULL  | result held on dout; din accepted only while dout.ready=1
module qacc #(
    parameter int W_DATA = 16,
    parameter int W_SUM  = 24,
    parameter int W_CNT  = 16,
    parameter int SIGNED = 0
) (
    input logic   clk,
    input logic   rst,
    dti.consumer  din,
    dti.producer  dout
);
    import qacc_pkg::*;

`ifdef QACC_SAT_EN
    localparam int W_OUT = W_CNT + W_SUM + 1;
`else
    localparam int W_OUT = W_CNT + W_SUM;
`endif

    if (($bits(din.data) != W_DATA + 1) || ($bits(dout.data) != W_OUT)) begin : g_width_check
        $fatal(1, "qacc: dti data widths do not match W_DATA/W_SUM/W_CNT");
    end

    typedef struct packed {
        logic              eot;
        logic [W_DATA-1:0] data;
    } in_word_t;

    typedef struct packed {
`ifdef QACC_SAT_EN
        logic             ovf;
`endif
        logic [W_CNT-1:0] cnt;
        logic [W_SUM-1:0] sum;
    } out_word_t;

    qacc_state_e      state;
    in_word_t         in_word;
    out_word_t        out_reg;
    logic [W_SUM-1:0] acc_sum;
    logic [W_SUM-1:0] sum_next;
    logic [W_CNT-1:0] acc_cnt;
    logic [W_CNT-1:0] cnt_next;
    logic             din_hs;
    logic             dout_hs;
`ifdef QACC_SAT_EN
    logic             acc_ovf;
    logic             ovf_next;
`endif

    assign in_word    = in_word_t'(din.data);
    assign din.ready  = (state == ST_EMPTY) | dout.ready;
    assign din_hs     = din.valid & din.ready;
    assign dout.valid = (state == ST_FULL);
    assign dout_hs    = dout.valid & dout.ready;
    assign dout.data  = out_reg;
    assign cnt_next   = acc_cnt + W_CNT'(1);

    qacc_add #(
        .W_DATA (W_DATA),
        .W_SUM  (W_SUM),
        .SIGNED (SIGNED)
    ) u_add (
        .acc_sum  (acc_sum),
        .data     (in_word.data),
`ifdef QACC_SAT_EN
        .acc_ovf  (acc_ovf),
        .ovf_next (ovf_next),
`endif
        .sum_next (sum_next)
    );

    // Accumulate non-eot words; on eot load the result and restart from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_EMPTY;
            acc_sum <= '0;
            acc_cnt <= '0;
            out_reg <= '0;
`ifdef QACC_SAT_EN
            acc_ovf <= 1'b0;
`endif
        end else begin
            if (din_hs && in_word.eot) begin
                out_reg.cnt <= cnt_next;
                out_reg.sum <= sum_next;
`ifdef QACC_SAT_EN
                out_reg.ovf <= ovf_next;
                acc_ovf     <= 1'b0;
`endif
                acc_sum <= '0;
                acc_cnt <= '0;
                state   <= ST_FULL;
            end else begin
                if (din_hs) begin
                    acc_sum <= sum_next;
                    acc_cnt <= cnt_next;
`ifdef QACC_SAT_EN
                    acc_ovf <= ovf_next;
`endif
                end
                if (dout_hs) begin
                    state <= ST_EMPTY;
                end
            end
        end
    end

endmodule

// File: tb/tb_qacc.sv
// tb_qacc: directed and randomized checks of qacc against a behavioural model.
module tb_qacc;

`ifdef QACC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
    localparam int WA_O  = 16 + 24 + (SAT_EN ? 1 : 0);
    localparam int WB_O  = 4 + 8 + (SAT_EN ? 1 : 0);
    localparam int N_TXN = 1000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dti #(.W(17))   a_in ();
    dti #(.W(WA_O)) a_out ();
    dti #(.W(9))    b_in ();
    dti #(.W(WB_O)) b_out ();
    dti #(.W(9))    c_in ();
    dti #(.W(WB_O)) c_out ();

    qacc #(.W_DATA(16), .W_SUM(24), .W_CNT(16), .SIGNED(0)) dut_a (
        .clk (clk), .rst (rst), .din (a_in), .dout (a_out));
    qacc #(.W_DATA(8), .W_SUM(8), .W_CNT(4), .SIGNED(1)) dut_b (
        .clk (clk), .rst (rst), .din (b_in), .dout (b_out));
    qacc #(.W_DATA(8), .W_SUM(8), .W_CNT(4), .SIGNED(0)) dut_c (
        .clk (clk), .rst (rst), .din (c_in), .dout (c_out));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Result of one transaction from the arithmetic rules: count, sum (wrapped or clamped), ovf.
    function automatic logic [63:0] ref_result(input longint vals[$], input int wd,
                                               input int ws, input int wc, input bit sgn);
        longint     s;
        longint     x;
        longint     hi;
        longint     lo;
        bit         ovf;
        logic [63:0] r;
        s   = 0;
        ovf = 1'b0;
        hi  = sgn ? (longint'(1) << (ws - 1)) - 1 : (longint'(1) << ws) - 1;
        lo  = sgn ? -(longint'(1) << (ws - 1)) : 0;
        foreach (vals[i]) begin
            x = vals[i] & ((longint'(1) << wd) - 1);
            if (sgn && x >= (longint'(1) << (wd - 1))) x -= longint'(1) << wd;
            s += x;
            if (SAT_EN) begin
                if (s > hi) begin s = hi; ovf = 1'b1; end
                else if (s < lo) begin s = lo; ovf = 1'b1; end
            end
        end
        r = (64'(vals.size()) & ((64'd1 << wc) - 64'd1)) << ws;
        r |= 64'(s) & ((64'd1 << ws) - 64'd1);
        if (ovf) r |= 64'd1 << (wc + ws);
        return r;
    endfunction

    // Offer one word to dut_a from a negedge; returns at the negedge after it is taken.
    task automatic a_push(input bit eot, input logic [15:0] d);
        bit ok;
        ok = 1'b0;
        a_in.data  = {eot, d};
        a_in.valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (a_in.ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) check_eq("push_ready_timeout", a_in.ready, 1);
        @(negedge clk);
        a_in.valid = 1'b0;
    endtask

    // Feed one transaction to dut_b and dut_c in lockstep (dout.ready stays 1) and check both.
    task automatic run_bc(input longint q[$]);
        for (int i = 0; i < q.size(); i++) begin
            b_in.valid = 1'b1;
            c_in.valid = 1'b1;
            b_in.data  = {i == q.size() - 1, 8'(q[i])};
            c_in.data  = {i == q.size() - 1, 8'(q[i])};
            @(negedge clk);
        end
        b_in.valid = 1'b0;
        c_in.valid = 1'b0;
        #1;
        check_eq("bc_signed_valid", b_out.valid, 1);
        check_eq("bc_signed_data", b_out.data, ref_result(q, 8, 8, 4, 1'b1));
        check_eq("bc_unsigned_valid", c_out.valid, 1);
        check_eq("bc_unsigned_data", c_out.data, ref_result(q, 8, 8, 4, 1'b0));
        @(negedge clk);
        #1;
        check_eq("bc_signed_drained", b_out.valid, 0);
    endtask

    longint      q[$];
    longint      cur[$];
    logic [63:0] sb[$];
    logic [63:0] held;
    logic [63:0] exp_w;
    bit          hold_chk;
    bit          in_acc;
    int          pos;
    int          txn_made;
    int          txn_done;
    int          len;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_in.valid  = 1'b0; a_in.data  = '0; a_out.ready = 1'b1;
        b_in.valid  = 1'b0; b_in.data  = '0; b_out.ready = 1'b1;
        c_in.valid  = 1'b0; c_in.data  = '0; c_out.ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_valid", a_out.valid, 0);
        check_eq("reset_data", a_out.data, 0);
        check_eq("reset_valid_b", b_out.valid, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("ready_after_reset", a_in.ready, 1);

        // 0,1,2,3(eot): cnt=4 sum=6, one cycle after the eot handshake
        for (int v = 0; v < 4; v++) begin
            #1;
            check_eq("t1_din_ready", a_in.ready, 1);
            if (v == 3) check_eq("t1_valid_before_eot", a_out.valid, 0);
            a_push(v == 3, 16'(v));
        end
        #1;
        check_eq("t1_valid", a_out.valid, 1);
        check_eq("t1_data", a_out.data, 64'h0400_0006);
        @(negedge clk);
        #1;
        check_eq("t1_drained", a_out.valid, 0);

        // Zero extension on the unsigned 16-bit instance
        a_push(1'b0, 16'h00FF);
        a_push(1'b1, 16'h00FE);
        #1;
        check_eq("zext_data", a_out.data, 64'h0200_01FD);
        @(negedge clk);

        // Back-pressure: 5,7,9 single-element transactions
        a_out.ready = 1'b0;
        a_push(1'b1, 16'd5);
        #1;
        check_eq("bp_first_valid", a_out.valid, 1);
        check_eq("bp_first_data", a_out.data, 64'h0100_0005);
        check_eq("bp_din_stalled", a_in.ready, 0);
        a_in.data  = {1'b1, 16'd7};
        a_in.valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            check_eq("bp_hold_valid", a_out.valid, 1);
            check_eq("bp_hold_data", a_out.data, 64'h0100_0005);
            check_eq("bp_hold_din_ready", a_in.ready, 0);
        end
        a_out.ready = 1'b1;
        #1;
        check_eq("bp_release_ready", a_in.ready, 1);
        @(negedge clk);
        #1;
        check_eq("bp_second_valid", a_out.valid, 1);
        check_eq("bp_second_data", a_out.data, 64'h0100_0007);
        a_in.data = {1'b1, 16'd9};
        @(negedge clk);
        #1;
        check_eq("bp_third_valid", a_out.valid, 1);
        check_eq("bp_third_data", a_out.data, 64'h0100_0009);
        a_in.valid = 1'b0;
        @(negedge clk);
        #1;
        check_eq("bp_no_duplicate", a_out.valid, 0);

        // Reset drops a pending result asynchronously
        a_out.ready = 1'b0;
        a_push(1'b1, 16'd8);
        #2;
        rst = 1'b0;
        #1;
        check_eq("rst_async_valid", a_out.valid, 0);
        check_eq("rst_async_data", a_out.data, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst_release_ready", a_in.ready, 1);
        check_eq("rst_release_valid", a_out.valid, 0);

        // Reset mid-transaction discards the partial sum
        a_out.ready = 1'b1;
        a_push(1'b0, 16'd10);
        a_push(1'b0, 16'd20);
        rst = 1'b0;
        #1;
        check_eq("rst_mid_valid", a_out.valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        a_push(1'b1, 16'd3);
        #1;
        check_eq("rst_mid_result_valid", a_out.valid, 1);
        check_eq("rst_mid_result_data", a_out.data, 64'h0100_0003);
        @(negedge clk);
        #1;
        check_eq("rst_mid_single", a_out.valid, 0);

        // Narrow instances: sign extension, wrap/saturate, count wrap
        q = '{255, 254};         run_bc(q);
        q = '{200, 100};         run_bc(q);
        q = '{1};                run_bc(q);
        q = '{127, 1};           run_bc(q);
        q = '{128, 255};         run_bc(q);
        q = '{};
        for (int i = 0; i < 17; i++) q.push_back(1);
        run_bc(q);

        // Randomized valid/ready against the scoreboard
        cur.delete();
        pos      = 0;
        txn_made = 0;
        txn_done = 0;
        hold_chk = 1'b0;
        in_acc   = 1'b0;
        a_in.valid = 1'b0;
        for (int cyc = 0; cyc < 80000 && txn_done < N_TXN; cyc++) begin
            @(negedge clk);
            if (hold_chk) begin
                check_eq("rand_hold_valid", a_out.valid, 1);
                check_eq("rand_hold_data", a_out.data, held);
            end
            if (in_acc) begin
                a_in.valid = 1'b0;
                in_acc     = 1'b0;
            end
            if (!a_in.valid) begin
                if (pos >= cur.size() && txn_made < N_TXN) begin
                    cur.delete();
                    len = $urandom_range(1, 20);
                    for (int i = 0; i < len; i++) cur.push_back(longint'($urandom_range(0, 65535)));
                    sb.push_back(ref_result(cur, 16, 24, 16, 1'b0));
                    pos = 0;
                    txn_made++;
                end
                if (pos < cur.size() && $urandom_range(0, 3) != 0) begin
                    a_in.valid = 1'b1;
                    a_in.data  = {pos == cur.size() - 1, 16'(cur[pos])};
                end
            end
            a_out.ready = ($urandom_range(0, 2) != 0);
            #1;
            if (a_in.valid && a_in.ready) begin
                in_acc = 1'b1;
                pos++;
            end
            if (a_out.valid && a_out.ready) begin
                exp_w = 64'hFFFF_FFFF_FFFF_FFFF;
                if (sb.size() != 0) exp_w = sb.pop_front();
                check_eq("rand_result", a_out.data, exp_w);
                txn_done++;
                hold_chk = 1'b0;
            end else if (a_out.valid) begin
                held     = a_out.data;
                hold_chk = 1'b1;
            end else begin
                hold_chk = 1'b0;
            end
        end
        check_eq("rand_txn_count", txn_done, N_TXN);
        check_eq("rand_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/qacc.md
Name: qacc

Overview:
- Downstream consumer for queue producers such as the range generator: takes a queue stream of data words terminated by an eot flag.
- Reduces each transaction to one output word holding element count and running sum.
- Emits that word once per transaction, one cycle after the eot handshake.
- Sits between a queue source and any block needing per-transaction totals (statistics, length checks, reduce stages).

Parameters:
- W_DATA, 16, width of the data field of din (din.data is W_DATA+1 bits including eot)
- W_SUM, 24, width of the accumulated sum
- W_CNT, 16, width of the element counter
- SIGNED, 0, 1 = data sign-extended to W_SUM before adding; 0 = zero-extended

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low (asserted when 0)
- din  dti.consumer  W_DATA+1  queue input: {eot, data}
- dout  dti.producer  W_CNT+W_SUM  result: {cnt, sum}

Behaviour:
- Reset (rst=0, async): acc_sum=0, acc_cnt=0, out_valid=0, out register=0. dout.valid=0 immediately on reset assertion. din.ready=1 after reset is released.
- Handshakes follow dti rules:
  - Transfer on valid & ready.
  - dout.valid and dout.data must be held stable until dout.ready.
  - din.ready never depends combinationally on din.valid.
- din.ready = !out_valid | dout.ready: a single output register; a new eot may be accepted in the same cycle the previous result drains.
- Non-eot handshake: acc_sum <= acc_sum + ext(data); acc_cnt <= acc_cnt + 1.
- Eot handshake:
  - out register <= {acc_cnt+1, acc_sum+ext(data)}; out_valid <= 1.
  - acc_sum <= 0; acc_cnt <= 0, so the next transaction starts clean in the next cycle.
- Latency: dout.valid rises exactly 1 cycle after the eot handshake. Throughput is one element per cycle with no bubbles between transactions while dout.ready=1.
- dout handshake without a new eot: out_valid <= 0. With a simultaneous eot handshake: out_valid stays 1 and the register loads the new result.
- Arithmetic:
  - ext() sign-extends if SIGNED, else zero-extends. If W_DATA > W_SUM, data is truncated to W_SUM LSBs.
  - Sum wraps modulo 2^W_SUM; count wraps modulo 2^W_CNT.
  - A single-element transaction (eot on first word) yields cnt=1, sum=data.
- No empty transactions: cnt is always ≥1.
- Reset mid-transaction: the partial accumulation and any pending output are discarded; no result is emitted for that transaction.
- State machine (2 states, encoded by out_valid):
  - EMPTY → FULL on eot handshake.
  - FULL → EMPTY on dout handshake without an eot handshake.
  - FULL → FULL on dout handshake with an eot handshake.
  - FULL stalls din while dout.ready=0.
- Initial assertion: W_CNT+W_SUM == $size(dout.data) and W_DATA+1 == $size(din.data); $fatal otherwise.

Optional Feature:
- Macro QACC_SAT_EN.
- Defined: the sum saturates instead of wrapping.
  - Unsigned: clamps at 2^W_SUM-1.
  - Signed: clamps at max positive / min negative.
  - A sticky per-transaction ovf bit is appended as the MSB of dout.data (width W_CNT+W_SUM+1), cleared on eot with the accumulators.
- Undefined: wrap-around arithmetic, no ovf bit, dout width W_CNT+W_SUM.
- The width assertion tracks the macro.

Decomposition:
- Shared package qacc_pkg:
  - din_t struct {eot, data}
  - dout_t struct {cnt, sum} (plus ovf under QACC_SAT_EN)
  - ext() sign/zero-extend function parameterised by SIGNED
- One sub-module is natural: qacc_add, the combinational extend-and-add with optional saturation and ovf generation. Top keeps the registers and handshake logic.

Test Plan:
- Unsigned queue 0,1,2,3(eot), dout.ready=1 → one dout word cnt=4, sum=6, 1 cycle after the eot handshake; din.ready held 1 throughout.
- SIGNED=1, W_DATA=8: queue 0xFF,0xFE(eot) → cnt=2, sum=-3 (0xFFFFFD for W_SUM=24). SIGNED=0 with the same input → sum=0x1FD.
- Back-pressure: three single-element transactions 5,7,9 with dout.ready=0 for 10 cycles:
  - First result held stable (cnt=1, sum=5).
  - din.ready=0 after the first eot.
  - After release, results 5, 7, 9 arrive in order with no loss or duplication.
- Wrap vs. saturate with W_SUM=8, unsigned:
  - Without QACC_SAT_EN: 200,100(eot) → sum=44.
  - With QACC_SAT_EN: sum=255, ovf=1; the next transaction 1(eot) → sum=1, ovf=0.
- Reset mid-operation: 10,20 accepted, then rst=0 for 2 cycles, then 3(eot) → dout.valid low during reset, then a single result cnt=1, sum=3.
- Random valid/ready toggling, 1000 transactions of random length 1–20 → results match the reference model, dout.data stable while valid & !ready.
